ysyx_23060337_wbu: RTL and testbench
====================================

# ysyx_23060337_wbu

Write-back unit for the NPC core: the writer side of the general-purpose register file. It accepts completed results from the execute unit (EXU) and the load/store unit (LSU) over valid/ready channels and arbitrates them onto the register file's single write port, one write per cycle. It also keeps a pending-write scoreboard, which decode uses to detect read-after-write hazards.

## Interface

Parameters:
- ADDR_WIDTH, 5, register index width; the register file has 2**ADDR_WIDTH entries
- DATA_WIDTH, 32, register data width
- STARVE_LIMIT, 4, consecutive denied EXU cycles before EXU gets priority (1..15)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset, asynchronous, active-low
- exu_valid  in  1  EXU result valid
- exu_ready  out  1  WBU accepts the EXU result this cycle
- exu_rd  in  ADDR_WIDTH  EXU destination register
- exu_data  in  DATA_WIDTH  EXU result
- lsu_valid  in  1  LSU result valid
- lsu_ready  out  1  WBU accepts the LSU result this cycle
- lsu_rd  in  ADDR_WIDTH  LSU destination register
- lsu_data  in  DATA_WIDTH  load data
- alloc_valid  in  1  decode issued an instruction that writes alloc_rd
- alloc_rd  in  ADDR_WIDTH  destination register being allocated
- busy  out  2**ADDR_WIDTH  pending-write mask; bit i = register i awaiting write-back
- rf_wen  out  1  register file write enable
- rf_waddr  out  ADDR_WIDTH  register file write address
- rf_wdata  out  DATA_WIDTH  register file write data
- retire_cnt  out  32  count of accepted write-back transactions

## Operation

- Handshake: a transfer occurs on a channel when valid and ready are both high at posedge. Sources hold rd and data stable while valid is high and ready is low.
- Arbitration: at most one channel is ready per cycle. Readies are combinational from the valids and the starvation counter.
  - Default: LSU has priority. lsu_ready = lsu_valid. exu_ready = exu_valid & ~lsu_valid.
  - starve_cnt increments each cycle in which exu_valid=1 and exu_ready=0, saturating at STARVE_LIMIT. It clears to 0 on any EXU transfer or when exu_valid=0.
  - When starve_cnt == STARVE_LIMIT, EXU has priority: exu_ready = exu_valid, lsu_ready = lsu_valid & ~exu_valid.
- Output register: the accepted rd/data is registered into rf_waddr/rf_wdata. rf_wen = 1 in the following cycle, provided rd != 0.
- When no transfer occurs, rf_wen = 0 next cycle. rf_waddr and rf_wdata hold their last values.
- rd == 0: the transfer still completes (ready high, retire_cnt increments), but rf_wen stays 0.
- Scoreboard:
  - busy[i] is set at posedge when alloc_valid=1 and alloc_rd=i.
  - busy[i] is cleared at posedge when rf_wen=1 and rf_waddr=i.
  - busy[0] is hardwired 0.
  - If set and clear hit the same register in the same cycle, set wins, because a newer producer is outstanding.
- retire_cnt increments by 1 on every transfer on either channel and wraps from 2**32-1 to 0.

## Timing

- Reset (rst_n low, asynchronous): rf_wen=0, rf_waddr=0, rf_wdata=0, busy=0, retire_cnt=0, starve_cnt=0.
- While rst_n is low, exu_ready and lsu_ready are forced to 0. A reset asserted mid-operation drops any registered write (rf_wen=0 immediately).
- Latency: a transfer at posedge N produces rf_wen=1 during cycle N..N+1. The register file captures the data at posedge N+1.
- The busy bit clears at the same posedge N+1, so a reader sees busy=0 and the new data in the same cycle.
- Throughput: one transfer per cycle sustained. There is no internal backpressure beyond arbitration.
- busy reflects allocations one cycle after alloc_valid.
- readies are combinational; valids never depend on readies.

## Test plan

- Reset release, then EXU valid (rd=5, data=0xDEADBEEF) with LSU idle: exu_ready=1 the same cycle; next cycle rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF; retire_cnt=1.
- Both channels valid (LSU rd=3 data=0x11, EXU rd=4 data=0x22): LSU accepted first (lsu_ready=1, exu_ready=0); EXU accepted the following cycle; rf writes r3 then r4 on consecutive cycles.
- LSU valid continuously and EXU valid continuously, STARVE_LIMIT=4: EXU is denied 4 cycles, then accepted on the 5th cycle with lsu_ready=0; LSU resumes the cycle after.
- Write to rd=0 (data=0xFFFFFFFF): handshake completes and retire_cnt increments; rf_wen stays 0; busy[0] stays 0.
- alloc r7, then EXU write r7 four cycles later: busy[7]=1 from the next cycle until it clears with rf_wen. Repeat with alloc_rd=7 in the same cycle as rf_wen for r7: busy[7] remains 1.
- Drive rst_n low during the cycle rf_wen=1: rf_wen drops immediately, busy=0 and retire_cnt=0; after release, the first transfer behaves as in scenario 1.

Source files
------------

// File: rtl/ysyx_23060337_wbu.sv
// Write-back unit: arbitrates EXU/LSU results onto the register file write port and
// tracks pending writes. Latency: a transfer at posedge N drives rf_wen during cycle N..N+1.
// Backpressure: one transfer per cycle. LSU wins by default; a starved EXU wins once.
module ysyx_23060337_wbu #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       exu_valid,
  output logic                       exu_ready,
  input  logic [ADDR_WIDTH-1:0]      exu_rd,
  input  logic [DATA_WIDTH-1:0]      exu_data,
  input  logic                       lsu_valid,
  output logic                       lsu_ready,
  input  logic [ADDR_WIDTH-1:0]      lsu_rd,
  input  logic [DATA_WIDTH-1:0]      lsu_data,
  input  logic                       alloc_valid,
  input  logic [ADDR_WIDTH-1:0]      alloc_rd,
  output logic [(2**ADDR_WIDTH)-1:0] busy,
  output logic                       rf_wen,
  output logic [ADDR_WIDTH-1:0]      rf_waddr,
  output logic [DATA_WIDTH-1:0]      rf_wdata,
  output logic [31:0]                retire_cnt
);

  localparam int NREG = 2**ADDR_WIDTH;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]            r_starve_cnt;
  logic                  r_rf_wen;
  logic [ADDR_WIDTH-1:0] r_rf_waddr;
  logic [DATA_WIDTH-1:0] r_rf_wdata;
  logic [NREG-1:0]       r_busy;
  logic [31:0]           r_retire_cnt;

  logic                  w_exu_pri;
  logic                  w_exu_xfer;
  logic                  w_lsu_xfer;
  logic                  w_any_xfer;
  logic [ADDR_WIDTH-1:0] w_sel_rd;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [NREG-1:0]       w_set_mask;
  logic [NREG-1:0]       w_clr_mask;

  // Arbitration: readies are combinational and gated off while reset is asserted.
  always_comb begin
    w_exu_pri = (r_starve_cnt == LIMIT);
    exu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (rst_n) begin
      if (w_exu_pri) begin
        exu_ready = exu_valid;
        lsu_ready = lsu_valid & ~exu_valid;
      end else begin
        lsu_ready = lsu_valid;
        exu_ready = exu_valid & ~lsu_valid;
      end
    end
    w_exu_xfer = exu_valid & exu_ready;
    w_lsu_xfer = lsu_valid & lsu_ready;
    w_any_xfer = w_exu_xfer | w_lsu_xfer;
    w_sel_rd   = w_exu_xfer ? exu_rd   : lsu_rd;
    w_sel_data = w_exu_xfer ? exu_data : lsu_data;
  end

  // Scoreboard masks: a new allocation outranks the clear from a write of the same register.
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (alloc_valid) w_set_mask[alloc_rd] = 1'b1;
    if (r_rf_wen)    w_clr_mask[r_rf_waddr] = 1'b1;
  end

  // Starvation counter: counts consecutive denied EXU cycles, saturating at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (!exu_valid || w_exu_xfer) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt < LIMIT) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  // Write port register: writes to x0 complete the handshake but never enable the write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_wen   <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else if (w_any_xfer) begin
      r_rf_wen   <= (w_sel_rd != '0);
      r_rf_waddr <= w_sel_rd;
      r_rf_wdata <= w_sel_data;
    end else begin
      r_rf_wen   <= 1'b0;
    end
  end

  // Pending-write scoreboard; x0 is never busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= ((r_busy & ~w_clr_mask) | w_set_mask) & ~NREG'(1);
    end
  end

  // Retired transaction counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retire_cnt <= '0;
    end else if (w_any_xfer) begin
      r_retire_cnt <= r_retire_cnt + 32'd1;
    end
  end

  assign busy       = r_busy;
  assign rf_wen     = r_rf_wen;
  assign rf_waddr   = r_rf_waddr;
  assign rf_wdata   = r_rf_wdata;
  assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_ysyx_23060337_wbu.sv
// Directed bench for the write-back unit: arbitration, starvation, x0 writes,
// scoreboard set/clear ordering and asynchronous reset mid-write.
module tb_ysyx_23060337_wbu;

  logic        clk;
  logic        rst_n;
  logic        exu_valid;
  logic        exu_ready;
  logic [4:0]  exu_rd;
  logic [31:0] exu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        alloc_valid;
  logic [4:0]  alloc_rd;
  logic [31:0] busy;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] retire_cnt;

  int n_checks = 0;
  int n_fails  = 0;

  ysyx_23060337_wbu #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .busy(busy),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .retire_cnt(retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    exu_valid = 1'b1; exu_rd = 5'd1; exu_data = 32'h1;
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h2;
    alloc_valid = 1'b0; alloc_rd = 5'd0;
    #2;
    check("rst_rf_wen", 64'(rf_wen), 64'd0);
    check("rst_rf_waddr", 64'(rf_waddr), 64'd0);
    check("rst_rf_wdata", 64'(rf_wdata), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_retire", 64'(retire_cnt), 64'd0);
    check("rst_exu_ready", 64'(exu_ready), 64'd0);
    check("rst_lsu_ready", 64'(lsu_ready), 64'd0);
    tick(); tick();
    exu_valid = 1'b0; lsu_valid = 1'b0;
    rst_n = 1'b1;

    // Scenario 1: single EXU write
    exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'hDEADBEEF;
    #1;
    check("s1_exu_ready", 64'(exu_ready), 64'd1);
    check("s1_lsu_ready", 64'(lsu_ready), 64'd0);
    tick();
    exu_valid = 1'b0;
    check("s1_rf_wen", 64'(rf_wen), 64'd1);
    check("s1_rf_waddr", 64'(rf_waddr), 64'd5);
    check("s1_rf_wdata", 64'(rf_wdata), 64'hDEADBEEF);
    check("s1_retire", 64'(retire_cnt), 64'd1);

    // Scenario 2: both valid, LSU first then EXU
    lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h11;
    exu_valid = 1'b1; exu_rd = 5'd4; exu_data = 32'h22;
    #1;
    check("s2_lsu_ready", 64'(lsu_ready), 64'd1);
    check("s2_exu_ready", 64'(exu_ready), 64'd0);
    tick();
    lsu_valid = 1'b0;
    check("s2_w1_addr", 64'(rf_waddr), 64'd3);
    check("s2_w1_data", 64'(rf_wdata), 64'h11);
    check("s2_w1_wen", 64'(rf_wen), 64'd1);
    #1;
    check("s2_exu_ready2", 64'(exu_ready), 64'd1);
    tick();
    exu_valid = 1'b0;
    check("s2_w2_addr", 64'(rf_waddr), 64'd4);
    check("s2_w2_data", 64'(rf_wdata), 64'h22);
    check("s2_retire", 64'(retire_cnt), 64'd3);
    tick();
    check("s2_idle_wen", 64'(rf_wen), 64'd0);
    check("s2_hold_addr", 64'(rf_waddr), 64'd4);
    check("s2_hold_data", 64'(rf_wdata), 64'h22);

    // Scenario 3: EXU starvation with both valid continuously
    lsu_valid = 1'b1; lsu_rd = 5'd8; lsu_data = 32'h80;
    exu_valid = 1'b1; exu_rd = 5'd9; exu_data = 32'h90;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("s3_deny_exu_%0d", i), 64'(exu_ready), 64'd0);
      check($sformatf("s3_deny_lsu_%0d", i), 64'(lsu_ready), 64'd1);
      tick();
      check($sformatf("s3_lsu_wr_%0d", i), 64'(rf_waddr), 64'd8);
    end
    #1;
    check("s3_pri_exu", 64'(exu_ready), 64'd1);
    check("s3_pri_lsu", 64'(lsu_ready), 64'd0);
    tick();
    check("s3_exu_wr", 64'(rf_waddr), 64'd9);
    check("s3_exu_data", 64'(rf_wdata), 64'h90);
    #1;
    check("s3_resume_lsu", 64'(lsu_ready), 64'd1);
    check("s3_resume_exu", 64'(exu_ready), 64'd0);
    tick();
    lsu_valid = 1'b0; exu_valid = 1'b0;
    check("s3_lsu_again", 64'(rf_waddr), 64'd8);
    check("s3_retire", 64'(retire_cnt), 64'd9);
    tick();

    // Scenario 4: write to x0, with a simultaneous allocation of x0
    exu_valid = 1'b1; exu_rd = 5'd0; exu_data = 32'hFFFFFFFF;
    alloc_valid = 1'b1; alloc_rd = 5'd0;
    #1;
    check("s4_exu_ready", 64'(exu_ready), 64'd1);
    tick();
    exu_valid = 1'b0; alloc_valid = 1'b0;
    check("s4_wen", 64'(rf_wen), 64'd0);
    check("s4_retire", 64'(retire_cnt), 64'd10);
    check("s4_busy0", 64'(busy), 64'd0);
    tick();

    // Scenario 5a: allocate r7, write it back later
    alloc_valid = 1'b1; alloc_rd = 5'd7;
    tick();
    alloc_valid = 1'b0;
    check("s5_busy_set", 64'(busy), 64'h80);
    tick();
    check("s5_busy_hold1", 64'(busy), 64'h80);
    tick();
    check("s5_busy_hold2", 64'(busy), 64'h80);
    exu_valid = 1'b1; exu_rd = 5'd7; exu_data = 32'h77;
    tick();
    exu_valid = 1'b0;
    check("s5_wen", 64'(rf_wen), 64'd1);
    check("s5_busy_wen", 64'(busy), 64'h80);
    tick();
    check("s5_busy_clr", 64'(busy), 64'd0);
    check("s5_wen_off", 64'(rf_wen), 64'd0);

    // Scenario 5b: re-allocation in the same cycle as the clearing write
    alloc_valid = 1'b1; alloc_rd = 5'd7;
    tick();
    alloc_valid = 1'b0;
    check("s5b_busy_set", 64'(busy), 64'h80);
    exu_valid = 1'b1; exu_rd = 5'd7; exu_data = 32'h78;
    tick();
    exu_valid = 1'b0;
    check("s5b_wen", 64'(rf_wen), 64'd1);
    check("s5b_waddr", 64'(rf_waddr), 64'd7);
    alloc_valid = 1'b1; alloc_rd = 5'd7;
    tick();
    alloc_valid = 1'b0;
    check("s5b_set_wins", 64'(busy), 64'h80);
    tick();
    check("s5b_still_busy", 64'(busy), 64'h80);
    check("s5b_retire", 64'(retire_cnt), 64'd12);

    // Scenario 6: reset asserted while a write is registered
    exu_valid = 1'b1; exu_rd = 5'd10; exu_data = 32'hA;
    tick();
    check("s6_wen_before", 64'(rf_wen), 64'd1);
    check("s6_retire_before", 64'(retire_cnt), 64'd13);
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_wen_drop", 64'(rf_wen), 64'd0);
    check("s6_busy_clr", 64'(busy), 64'd0);
    check("s6_retire_clr", 64'(retire_cnt), 64'd0);
    check("s6_waddr_clr", 64'(rf_waddr), 64'd0);
    check("s6_exu_ready_forced", 64'(exu_ready), 64'd0);
    exu_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'hDEADBEEF;
    #1;
    check("s6_exu_ready", 64'(exu_ready), 64'd1);
    tick();
    exu_valid = 1'b0;
    check("s6_rf_wen", 64'(rf_wen), 64'd1);
    check("s6_rf_waddr", 64'(rf_waddr), 64'd5);
    check("s6_rf_wdata", 64'(rf_wdata), 64'hDEADBEEF);
    check("s6_retire", 64'(retire_cnt), 64'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
